// File: rtl/genlock_pkg.sv
// genlock_pkg: shared state encoding and default limits for the
// frame-lock supervisor.
package genlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_ALIGN,
    ST_LOCKED,
    ST_HOLD
  } state_t;

  localparam int unsigned DEF_FRAME_LEN_MIN = 780000;
  localparam int unsigned DEF_FRAME_LEN_MAX = 845000;
  localparam int unsigned DEF_LOCK_COUNT    = 4;
  localparam int unsigned DEF_LOSS_COUNT    = 2;
  localparam int unsigned DEF_PHASE_TOL     = 4;
  localparam int unsigned DEF_ALIGN_FRAMES  = 3;
  localparam int unsigned DEF_CNT_W         = 20;

endpackage

// File: rtl/genlock_ctrl_period_meter.sv
// period_meter: RX frame-sync edge detect, period measurement and
// good/bad/miss classification as one-cycle strobes.
module period_meter #(
  parameter int unsigned FRAME_LEN_MIN = 780000,
  parameter int unsigned FRAME_LEN_MAX = 845000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_rx_sync,
  output logic             o_edge,
  output logic             o_good,
  output logic             o_bad,
  output logic             o_miss,
  output logic [CNT_W-1:0] o_period
);

  localparam logic [CNT_W-1:0] LP_MIN = CNT_W'(FRAME_LEN_MIN);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(FRAME_LEN_MAX);

  logic             r_rx_prev;
  logic             r_stale;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] r_period;
  logic             w_edge;
  logic             w_limit;
  logic             w_measure;
  logic             w_inrange;
  logic [CNT_W-1:0] w_len;

  // w_len is the number of cycles since the last edge, this cycle included
  assign w_edge    = i_rx_sync & ~r_rx_prev;
  assign w_len     = r_elapsed + 1'b1;
  assign w_limit   = (r_elapsed == LP_MAX);
  assign w_inrange = (w_len >= LP_MIN) && (w_len <= LP_MAX);
  assign w_measure = w_edge & ~r_stale & ~i_clear;

  assign o_edge   = w_edge & ~i_clear;
  assign o_good   = w_measure & w_inrange;
  assign o_bad    = w_measure & ~w_inrange;
  assign o_miss   = ~i_clear & ~w_edge & w_limit;
  assign o_period = r_period;

  // Elapsed counter, stale flag and last-period register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_prev <= 1'b0;
      r_stale   <= 1'b1;
      r_elapsed <= '0;
      r_period  <= '0;
    end else begin
      r_rx_prev <= i_rx_sync;
      if (i_clear) begin
        r_stale   <= 1'b1;
        r_elapsed <= '0;
        r_period  <= '0;
      end else if (w_edge) begin
        r_stale   <= 1'b0;
        r_elapsed <= '0;
        if (!r_stale) r_period <= w_len;
      end else if (w_limit) begin
        r_stale   <= 1'b1;
        r_elapsed <= '0;
      end else begin
        r_elapsed <= w_len;
      end
    end
  end

endmodule

// File: rtl/genlock_ctrl.sv
// genlock_ctrl: frame-lock supervisor gating TX realignment to RX sync.
// Optional GENLOCK_TESTPAT_EN drives DEBUG_MODE while no valid input.
module genlock_ctrl
  import genlock_pkg::*;
#(
  parameter int unsigned FRAME_LEN_MIN = DEF_FRAME_LEN_MIN,
  parameter int unsigned FRAME_LEN_MAX = DEF_FRAME_LEN_MAX,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned LOSS_COUNT    = DEF_LOSS_COUNT,
  parameter int unsigned PHASE_TOL     = DEF_PHASE_TOL,
  parameter int unsigned ALIGN_FRAMES  = DEF_ALIGN_FRAMES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_rx_sync,
  input  logic             i_tx_frame_start,
  output logic             o_vga_sync_en,
  output logic             o_debug_mode,
  output logic             o_locked,
  output logic             o_sync_bad,
  output logic [CNT_W-1:0] o_period
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam int AW = $clog2(ALIGN_FRAMES + 1);
  localparam int WW = (PHASE_TOL > 0) ? $clog2(PHASE_TOL + 1) : 1;

  localparam logic [GW-1:0] LP_LOCK    = GW'(LOCK_COUNT);
  localparam logic [GW-1:0] LP_LOCK_M1 = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] LP_LOSS    = MW'(LOSS_COUNT);
  localparam logic [MW-1:0] LP_LOSS_M1 = MW'(LOSS_COUNT - 1);
  localparam logic [MW-1:0] LP_ONE     = MW'(1);
  localparam logic [AW-1:0] LP_ALN     = AW'(ALIGN_FRAMES);
  localparam logic [AW-1:0] LP_ALN_M1  = AW'(ALIGN_FRAMES - 1);
  localparam logic [WW-1:0] LP_TOL     = WW'(PHASE_TOL);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_good_cnt;
  logic [MW-1:0]   r_miss_cnt;
  logic [AW-1:0]   r_align_cnt;
  logic [WW-1:0]   r_win;
  logic            w_clear;
  logic            w_edge;
  logic            w_good;
  logic            w_bad;
  logic            w_miss;
  logic            w_fail;
  logic            w_in_win;
  logic            w_vse;
  logic            w_lck;
  logic            w_sbad;
  logic            w_dbg;

  assign w_clear  = i_rst | ~i_enable | (r_state == ST_IDLE);
  assign w_fail   = w_bad | w_miss;
  assign w_in_win = w_edge | (r_win != '0);

  period_meter #(
    .FRAME_LEN_MIN (FRAME_LEN_MIN),
    .FRAME_LEN_MAX (FRAME_LEN_MAX),
    .CNT_W         (CNT_W)
  ) u_meter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_rx_sync (i_rx_sync),
    .o_edge    (w_edge),
    .o_good    (w_good),
    .o_bad     (w_bad),
    .o_miss    (w_miss),
    .o_period  (o_period)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and Moore output decode
  always_comb begin
    w_state_nxt = r_state;
    w_vse       = 1'b0;
    w_lck       = 1'b0;
    w_sbad      = 1'b0;
    w_dbg       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (w_good && (r_good_cnt >= LP_LOCK_M1))
          w_state_nxt = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (w_fail)
          w_state_nxt = ST_SEARCH;
        else if (i_tx_frame_start && w_in_win)
          w_state_nxt = ST_LOCKED;
        else if (w_edge && (r_align_cnt >= LP_ALN_M1))
          w_state_nxt = ST_SEARCH;
      end
      ST_LOCKED: begin
        if (w_fail) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_good)
          w_state_nxt = ST_LOCKED;
        else if (w_fail && (r_miss_cnt >= LP_LOSS_M1))
          w_state_nxt = ST_SEARCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!i_enable) w_state_nxt = ST_IDLE;

    w_vse  = (r_state == ST_ALIGN) | (r_state == ST_LOCKED);
    w_lck  = (r_state == ST_LOCKED);
    w_sbad = (r_state == ST_SEARCH) | (r_state == ST_ALIGN) |
             (r_state == ST_HOLD);
`ifdef GENLOCK_TESTPAT_EN
    w_dbg  = (r_state == ST_IDLE) | (r_state == ST_SEARCH);
`else
    w_dbg  = 1'b0;
`endif
  end

  assign o_vga_sync_en = w_vse;
  assign o_locked      = w_lck;
  assign o_sync_bad    = w_sbad;
  assign o_debug_mode  = w_dbg;

  // Good-period, align-frame, miss counters and ALIGN phase window
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_good_cnt  <= '0;
      r_align_cnt <= '0;
      r_miss_cnt  <= '0;
      r_win       <= '0;
    end else begin
      if ((r_state != ST_SEARCH) || w_fail)
        r_good_cnt <= '0;
      else if (w_good && (r_good_cnt < LP_LOCK))
        r_good_cnt <= r_good_cnt + 1'b1;

      if (r_state != ST_ALIGN)
        r_align_cnt <= '0;
      else if (w_edge && (r_align_cnt < LP_ALN))
        r_align_cnt <= r_align_cnt + 1'b1;

      if (r_state != ST_ALIGN)
        r_win <= '0;
      else if (w_edge)
        r_win <= LP_TOL;
      else if (r_win != '0)
        r_win <= r_win - 1'b1;

      if (r_state == ST_LOCKED)
        r_miss_cnt <= w_fail ? LP_ONE : '0;
      else if (r_state == ST_HOLD) begin
        if (w_good)
          r_miss_cnt <= '0;
        else if (w_fail && (r_miss_cnt < LP_LOSS))
          r_miss_cnt <= r_miss_cnt + 1'b1;
      end else
        r_miss_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_genlock_ctrl.sv
// tb_genlock_ctrl: directed bench for genlock_ctrl with small frame
// limits; DEBUG_MODE expectations follow GENLOCK_TESTPAT_EN.
module tb_genlock_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx;
  logic       tx;
  logic       o_vga_sync_en;
  logic       o_debug_mode;
  logic       o_locked;
  logic       o_sync_bad;
  logic [7:0] o_period;

  int nerr;
  int nchk;

  genlock_ctrl #(
    .FRAME_LEN_MIN (100),
    .FRAME_LEN_MAX (120),
    .LOCK_COUNT    (4),
    .LOSS_COUNT    (2),
    .PHASE_TOL     (4),
    .ALIGN_FRAMES  (3),
    .CNT_W         (8)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (en),
    .i_rx_sync        (rx),
    .i_tx_frame_start (tx),
    .o_vga_sync_en    (o_vga_sync_en),
    .o_debug_mode     (o_debug_mode),
    .o_locked         (o_locked),
    .o_sync_bad       (o_sync_bad),
    .o_period         (o_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_dbg(input logic idle_or_search);
`ifdef GENLOCK_TESTPAT_EN
    return idle_or_search;
`else
    return 1'b0 & idle_or_search;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    rx = 1'b1;
    step(1);
    rx = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic vse, input logic lck,
                      input logic bad, input logic ios);
    chk1({tag, ".vse"}, o_vga_sync_en, vse);
    chk1({tag, ".lck"}, o_locked, lck);
    chk1({tag, ".bad"}, o_sync_bad, bad);
    chk1({tag, ".dbg"}, o_debug_mode, exp_dbg(ios));
  endtask

  // From SEARCH with stale set: 1 unmeasured + 4 good edges, then
  // TX_FRAME_START 2 cycles after the 6th edge. Leaves us 110 cycles
  // after the 6th edge, LOCKED.
  task automatic acquire(input string tag);
    pulse();
    for (int k = 0; k < 3; k++) begin
      step(109);
      pulse();
    end
    step(109);
    chk1({tag, ".pre_align"}, o_vga_sync_en, 1'b0);
    pulse();
    outs({tag, ".align"}, 1'b1, 1'b0, 1'b1, 1'b0);
    step(109);
    pulse();
    step(1);
    tx = 1'b1;
    step(1);
    tx = 1'b0;
    outs({tag, ".lock"}, 1'b1, 1'b1, 1'b0, 1'b0);
    chk8({tag, ".period"}, o_period, 8'd110);
    step(107);
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst  = 1'b1;
    en   = 1'b1;
    rx   = 1'b0;
    tx   = 1'b0;

    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      step(1);
    end
    outs("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk8("rst.period", o_period, 8'd0);
    rst = 1'b0;
    rx  = 1'b0;
    outs("rel", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    outs("search", 1'b0, 1'b0, 1'b1, 1'b1);

    acquire("acq1");

    pulse();
    chk1("p110.lck", o_locked, 1'b1);
    step(99);
    pulse();
    chk1("p100.lck", o_locked, 1'b1);
    chk8("p100.period", o_period, 8'd100);
    step(119);
    pulse();
    chk1("p120.lck", o_locked, 1'b1);
    chk8("p120.period", o_period, 8'd120);
    step(98);
    pulse();
    outs("p99", 1'b0, 1'b0, 1'b1, 1'b0);
    chk8("p99.period", o_period, 8'd99);
    step(109);
    pulse();
    chk1("p99.relock", o_locked, 1'b1);

    step(120);
    chk1("hold.pre", o_locked, 1'b1);
    step(1);
    outs("hold", 1'b0, 1'b0, 1'b1, 1'b0);
    step(98);
    pulse();
    chk1("hold.stale", o_locked, 1'b0);
    chk8("hold.period", o_period, 8'd110);
    step(109);
    pulse();
    outs("relock", 1'b1, 1'b1, 1'b0, 1'b0);

    step(121);
    outs("loss1", 1'b0, 1'b0, 1'b1, 1'b0);
    step(120);
    outs("loss1b", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    outs("loss2", 1'b0, 1'b0, 1'b1, 1'b1);

    acquire("acq2");

    en = 1'b0;
    step(1);
    outs("dis", 1'b0, 1'b0, 1'b0, 1'b1);
    chk8("dis.period", o_period, 8'd0);
    en = 1'b1;
    step(1);
    outs("en", 1'b0, 1'b0, 1'b1, 1'b1);

    pulse();
    for (int k = 0; k < 3; k++) begin
      step(109);
      pulse();
    end
    step(89);
    pulse();
    chk8("bad.period", o_period, 8'd90);
    for (int k = 0; k < 3; k++) begin
      step(109);
      pulse();
    end
    chk1("bad.3good", o_vga_sync_en, 1'b0);
    step(109);
    pulse();
    outs("bad.align", 1'b1, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 2; k++) begin
      step(9);
      tx = 1'b1;
      step(1);
      tx = 1'b0;
      step(99);
      pulse();
    end
    outs("late", 1'b1, 1'b0, 1'b1, 1'b0);
    step(9);
    tx = 1'b1;
    step(1);
    tx = 1'b0;
    step(99);
    pulse();
    outs("timeout", 1'b0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 3; k++) begin
      step(109);
      pulse();
    end
    chk1("win.pre", o_vga_sync_en, 1'b0);
    step(109);
    pulse();
    chk1("win.align", o_vga_sync_en, 1'b1);
    step(109);
    pulse();
    step(4);
    tx = 1'b1;
    step(1);
    tx = 1'b0;
    chk1("win.phase5", o_locked, 1'b0);
    step(104);
    pulse();
    step(3);
    tx = 1'b1;
    step(1);
    tx = 1'b0;
    chk1("win.phase4", o_locked, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
